// File: rtl/hwpe_ctrl_uloop_sched_pkg.sv
// ============================================================================
// Module : hwpe_ctrl_uloop_sched_pkg
// Brief  : uloop ctrl/flags types and scheduler state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package hwpe_ctrl_uloop_sched_pkg;

    localparam int unsigned ULOOP_NB_LOOPS      = 2;
    localparam int unsigned ULOOP_NB_REG        = 4;
    localparam int unsigned ULOOP_REG_WIDTH     = 32;
    localparam int unsigned ULOOP_CNT_WIDTH     = 8;
    localparam int unsigned ULOOP_LOOP_WIDTH    = (ULOOP_NB_LOOPS > 1) ? $clog2(ULOOP_NB_LOOPS) : 1;
    localparam int unsigned ULOOP_SCHED_TIMEOUT = 1024;

    typedef struct packed {
        logic enable;
        logic clear;
    } ctrl_uloop_t;

    typedef struct packed {
        logic                                             done;
        logic                                             valid;
        logic                                             ready;
        logic [ULOOP_NB_REG-1:0][ULOOP_REG_WIDTH-1:0]     offs;
        logic [ULOOP_NB_LOOPS-1:0][ULOOP_CNT_WIDTH-1:0]   idx;
        logic [ULOOP_LOOP_WIDTH-1:0]                      loop;
    } flags_uloop_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        REQ  = 3'd2,
        WAIT = 3'd3,
        OUT  = 3'd4,
        FIN  = 3'd5
    } uloop_sched_state_t;

endpackage

`default_nettype wire

// File: rtl/hwpe_ctrl_uloop_sched_wdog.sv
// ============================================================================
// Module : hwpe_ctrl_uloop_sched_wdog
// Brief  : Counts consecutive enabled cycles; flags expiry on the TIMEOUT-th.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hwpe_ctrl_uloop_sched_wdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    generate
        if (TIMEOUT == 0) begin : g_bypass
            logic w_unused;
            assign w_unused  = ^{clk_i, rst_ni, clear_i, en_i};
            assign expired_o = 1'b0;
        end else begin : g_count
            localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CW-1:0] c_last = CW'(TIMEOUT - 1);

            logic [CW-1:0] r_cnt;

            // Restarts whenever the enable drops, so only uninterrupted waits count.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_cnt <= '0;
                end else if (clear_i || !en_i) begin
                    r_cnt <= '0;
                end else if (r_cnt != c_last) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign expired_o = en_i && (r_cnt == c_last);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/hwpe_ctrl_uloop_sched.sv
// ============================================================================
// Module : hwpe_ctrl_uloop_sched
// Brief  : Drives a uloop, turns its offsets into per-stream address tuples.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hwpe_ctrl_uloop_sched
    import hwpe_ctrl_uloop_sched_pkg::*;
#(
    parameter int unsigned SHADOWED   = 1,
    parameter int unsigned NB_STREAM  = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = ULOOP_SCHED_TIMEOUT,
    parameter int unsigned ITER_WIDTH = 16
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       clear_i,
    input  logic                                       start_i,
    output logic                                       busy_o,
    output logic                                       done_o,
    output logic                                       err_o,
    output ctrl_uloop_t                                ctrl_uloop_o,
    input  flags_uloop_t                               flags_uloop_i,
    input  logic [NB_STREAM*ADDR_WIDTH-1:0]            base_addr_i,
    output logic                                       out_valid_o,
    input  logic                                       out_ready_i,
    output logic [NB_STREAM*ADDR_WIDTH-1:0]            out_addr_o,
    output logic [ULOOP_NB_LOOPS*ULOOP_CNT_WIDTH-1:0]  out_idx_o,
    output logic [ULOOP_LOOP_WIDTH-1:0]                out_loop_o,
    output logic                                       out_last_o,
    output logic [ITER_WIDTH-1:0]                      iter_cnt_o
);

    uloop_sched_state_t r_state, w_state_nxt;

    logic [NB_STREAM-1:0][ADDR_WIDTH-1:0]               r_base;
    logic [NB_STREAM-1:0][ADDR_WIDTH-1:0]               r_addr;
    logic [NB_STREAM-1:0][ADDR_WIDTH-1:0]               w_sum;
    logic [ULOOP_NB_LOOPS*ULOOP_CNT_WIDTH-1:0]          r_idx;
    logic [ULOOP_LOOP_WIDTH-1:0]                        r_loop;
    logic                                               r_last;
    logic                                               r_err;
    logic [ITER_WIDTH-1:0]                              r_iter;
    logic                                               w_expired;
    logic                                               w_capture;
    logic                                               w_timeout;
    logic                                               w_unused_flags;

    assign w_unused_flags = ^flags_uloop_i;
    assign w_capture      = (r_state == WAIT) && flags_uloop_i.valid;
    assign w_timeout      = (r_state == WAIT) && !flags_uloop_i.valid && w_expired;

    hwpe_ctrl_uloop_sched_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .en_i      (r_state == WAIT),
        .expired_o (w_expired)
    );

    generate
        for (genvar k = 0; k < NB_STREAM; k++) begin : g_stream
            assign w_sum[k] = r_base[k] + ADDR_WIDTH'(flags_uloop_i.offs[k]);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else if (clear_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start_i) w_state_nxt = CLR;
            CLR:  w_state_nxt = REQ;
            REQ:  if ((SHADOWED == 0) || flags_uloop_i.ready) w_state_nxt = WAIT;
            WAIT: begin
                if (flags_uloop_i.valid) w_state_nxt = OUT;
                else if (w_expired)      w_state_nxt = IDLE;
            end
            OUT:  if (out_ready_i) w_state_nxt = r_last ? FIN : REQ;
            FIN:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // In unshadowed mode enable is a level that must fall as soon as valid shows up.
    always_comb begin
        ctrl_uloop_o = '0;
        case (r_state)
            CLR:  ctrl_uloop_o.clear = 1'b1;
            REQ:  ctrl_uloop_o.enable = (SHADOWED == 0) ? 1'b1 : flags_uloop_i.ready;
            WAIT: begin
                ctrl_uloop_o.enable = (SHADOWED == 0) && !flags_uloop_i.valid;
                ctrl_uloop_o.clear  = w_timeout;
            end
            default: ctrl_uloop_o = '0;
        endcase
        if (clear_i) ctrl_uloop_o = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_base <= '0;
            r_addr <= '0;
            r_idx  <= '0;
            r_loop <= '0;
            r_last <= 1'b0;
            r_err  <= 1'b0;
            r_iter <= '0;
        end else if (clear_i) begin
            r_base <= '0;
            r_addr <= '0;
            r_idx  <= '0;
            r_loop <= '0;
            r_last <= 1'b0;
            r_err  <= 1'b0;
            r_iter <= '0;
        end else begin
            if ((r_state == IDLE) && start_i) begin
                r_base <= base_addr_i;
                r_iter <= '0;
                r_err  <= 1'b0;
            end
            if (w_capture) begin
                r_addr <= w_sum;
                r_idx  <= flags_uloop_i.idx;
                r_loop <= flags_uloop_i.loop;
                r_last <= flags_uloop_i.done;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if ((r_state == OUT) && out_ready_i && (r_iter != {ITER_WIDTH{1'b1}})) begin
                r_iter <= r_iter + 1'b1;
            end
        end
    end

    assign busy_o      = (r_state != IDLE);
    assign done_o      = (r_state == FIN);
    assign out_valid_o = (r_state == OUT);
    assign err_o       = r_err;
    assign out_addr_o  = r_addr;
    assign out_idx_o   = r_idx;
    assign out_loop_o  = r_loop;
    assign out_last_o  = r_last;
    assign iter_cnt_o  = r_iter;

endmodule

`default_nettype wire

// File: tb/tb_hwpe_ctrl_uloop_sched.sv
// ============================================================================
// Module : tb_hwpe_ctrl_uloop_sched
// Brief  : Two schedulers (shadowed / unshadowed) in lockstep against uloop models.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hwpe_ctrl_uloop_sched;
    import hwpe_ctrl_uloop_sched_pkg::*;

    localparam int NS   = 4;
    localparam int AW   = 32;
    localparam int IW   = 3;
    localparam int MAXT = 16;

    typedef struct packed {
        logic [NS*AW-1:0] addr;
        logic [15:0]      idx;
        logic             loop;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic start;
    logic out_ready;
    logic [NS*AW-1:0] base_addr;

    ctrl_uloop_t      ctrl      [2];
    flags_uloop_t     flags     [2];
    logic             busy      [2];
    logic             done      [2];
    logic             err       [2];
    logic             out_valid [2];
    logic             out_last  [2];
    logic [NS*AW-1:0] out_addr  [2];
    logic [15:0]      out_idx   [2];
    logic [0:0]       out_loop  [2];
    logic [IW-1:0]    iter      [2];

    logic [31:0] t_offs [MAXT][NS];
    logic [15:0] t_idx  [MAXT];
    logic        t_loop [MAXT];
    logic        t_done [MAXT];
    int          t_n;
    logic        mute;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            flags_uloop_t m_flags;
            int           m_ptr;

            // uloop model: one tuple per sampled enable, presented the next cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    m_ptr         <= 0;
                    m_flags       <= '0;
                    m_flags.ready <= 1'b1;
                end else begin
                    m_flags.valid <= 1'b0;
                    if (ctrl[g].clear) begin
                        m_ptr <= 0;
                    end else if (ctrl[g].enable && !mute && (m_ptr < t_n)) begin
                        m_flags.valid <= 1'b1;
                        for (int k = 0; k < NS; k++) m_flags.offs[k] <= t_offs[m_ptr][k];
                        m_flags.idx   <= t_idx[m_ptr];
                        m_flags.loop  <= t_loop[m_ptr];
                        m_flags.done  <= t_done[m_ptr];
                        m_ptr         <= m_ptr + 1;
                    end
                end
            end

            assign flags[g] = m_flags;

            hwpe_ctrl_uloop_sched #(
                .SHADOWED   ((g == 0) ? 1 : 0),
                .NB_STREAM  (NS),
                .ADDR_WIDTH (AW),
                .TIMEOUT    (16),
                .ITER_WIDTH (IW)
            ) u_dut (
                .clk_i         (clk),
                .rst_ni        (rst_n),
                .clear_i       (clear),
                .start_i       (start),
                .busy_o        (busy[g]),
                .done_o        (done[g]),
                .err_o         (err[g]),
                .ctrl_uloop_o  (ctrl[g]),
                .flags_uloop_i (flags[g]),
                .base_addr_i   (base_addr),
                .out_valid_o   (out_valid[g]),
                .out_ready_i   (out_ready),
                .out_addr_o    (out_addr[g]),
                .out_idx_o     (out_idx[g]),
                .out_loop_o    (out_loop[g]),
                .out_last_o    (out_last[g]),
                .iter_cnt_o    (iter[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s_busy%0d", tag, g), busy[g], 0);
            chk($sformatf("%s_valid%0d", tag, g), out_valid[g], 0);
            chk($sformatf("%s_done%0d", tag, g), done[g], 0);
        end
    endtask

    task automatic single_loop(input int n, input int step);
        t_n = n;
        for (int i = 0; i < n; i++) begin
            t_offs[i][0] = 32'(step * (i + 1));
            for (int k = 1; k < NS; k++) t_offs[i][k] = 32'((i + 1) * k * 'h40);
            t_idx[i]  = 16'(i);
            t_loop[i] = 1'b0;
            t_done[i] = (i == n - 1);
        end
    endtask

    task automatic run_seq(input logic [NS*AW-1:0] base, input int stall_at, input int stall_len,
                           input bit clr_first, input bit poke_start, input int exp_iter);
        exp_t e;
        int   acc   = 0;
        int   stall = 0;
        int   last_acc_cyc = -10;
        int   cyc   = 0;
        bit   fin   = 0;
        for (int i = 0; i < t_n; i++) begin
            for (int k = 0; k < NS; k++) e.addr[k*AW +: AW] = base[k*AW +: AW] + t_offs[i][k];
            e.idx  = t_idx[i];
            e.loop = t_loop[i];
            e.last = t_done[i];
            exp_q.push_back(e);
        end
        @(negedge clk);
        base_addr = base;
        start     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start     = poke_start;
        base_addr = ~base;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("busy_after_start%0d", g), busy[g], 1);
            chk($sformatf("err_cleared%0d", g), err[g], 0);
        end
        while (!fin && cyc < 400) begin
            cyc++;
            out_ready = 1'b0;
            clear     = 1'b0;
            if (done[0]) begin
                chk("done_after_last", 32'(cyc - last_acc_cyc), 1);
                chk("done_all_accepted", 32'(exp_q.size()), 0);
                for (int g = 0; g < 2; g++) begin
                    chk($sformatf("done%0d", g), done[g], 1);
                    chk($sformatf("iter%0d", g), iter[g], exp_iter);
                end
                fin   = 1;
                start = 1'b0;
            end else if (out_valid[0]) begin
                chk("valid_lockstep", out_valid[1], 1);
                if (exp_q.size() == 0) begin
                    chk("extra_tuple", out_valid[0], 0);
                    fin = 1;
                end else begin
                    for (int g = 0; g < 2; g++) begin
                        chk($sformatf("addr%0d_t%0d", g, acc), out_addr[g], exp_q[0].addr);
                        chk($sformatf("idx%0d_t%0d", g, acc), out_idx[g], exp_q[0].idx);
                        chk($sformatf("loop%0d_t%0d", g, acc), out_loop[g], exp_q[0].loop);
                        chk($sformatf("last%0d_t%0d", g, acc), out_last[g], exp_q[0].last);
                    end
                    if (clr_first) begin
                        out_ready = 1'b1;
                        clear     = 1'b1;
                        start     = 1'b0;
                        fin       = 1;
                    end else if (acc == stall_at && stall < stall_len) begin
                        stall++;
                        for (int g = 0; g < 2; g++)
                            chk($sformatf("no_enable_stall%0d", g), ctrl[g].enable, 0);
                    end else begin
                        out_ready = 1'b1;
                        void'(exp_q.pop_front());
                        acc++;
                        last_acc_cyc = cyc;
                    end
                end
            end
            @(negedge clk);
        end
        chk("seq_completed", fin, 1);
        out_ready = 1'b0;
        clear     = 1'b0;
        start     = 1'b0;
        chk_idle("post_seq");
        if (clr_first) begin
            for (int g = 0; g < 2; g++) chk($sformatf("iter_after_clear%0d", g), iter[g], 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int busy_cyc [2];
        int clr_cnt  [2];
        int done_cnt [2];

        rst_n     = 1'b0;
        clear     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        base_addr = '0;
        mute      = 1'b0;
        t_n       = 0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst_ctrl%0d", g), ctrl[g], 0);
            chk($sformatf("rst_err%0d", g), err[g], 0);
            chk($sformatf("rst_iter%0d", g), iter[g], 0);
            chk($sformatf("rst_addr%0d", g), out_addr[g], 0);
        end
        chk_idle("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Single loop, four tuples.
        single_loop(4, 8);
        run_seq({32'h4000, 32'h3000, 32'h2000, 32'h1000}, -1, 0, 0, 0, 4);

        // Backpressure on the second tuple.
        run_seq({32'h4000, 32'h3000, 32'h2000, 32'h1000}, 1, 5, 0, 0, 4);

        // Watchdog: the uloop never answers.
        mute = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int g = 0; g < 2; g++) begin
            busy_cyc[g] = 0;
            clr_cnt[g]  = 0;
            done_cnt[g] = 0;
        end
        for (int c = 0; c < 30; c++) begin
            for (int g = 0; g < 2; g++) begin
                if (busy[g])         busy_cyc[g]++;
                if (ctrl[g].clear)   clr_cnt[g]++;
                if (done[g])         done_cnt[g]++;
            end
            @(negedge clk);
        end
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("wdog_busy_cycles%0d", g), busy_cyc[g], 18);
            chk($sformatf("wdog_clear_pulses%0d", g), clr_cnt[g], 2);
            chk($sformatf("wdog_no_done%0d", g), done_cnt[g], 0);
            chk($sformatf("wdog_err%0d", g), err[g], 1);
        end
        mute = 1'b0;

        // clear_i on a handshake cycle.
        run_seq({32'h4000, 32'h3000, 32'h2000, 32'h1000}, -1, 0, 1, 0, 0);

        // Address wrap with start_i held during the sequence.
        t_n = 2;
        for (int i = 0; i < 2; i++) begin
            t_offs[i][0] = (i == 0) ? 32'h20 : 32'h30;
            for (int k = 1; k < NS; k++) t_offs[i][k] = 32'h1;
            t_idx[i]  = 16'(i);
            t_loop[i] = 1'b0;
            t_done[i] = (i == 1);
        end
        run_seq({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF0}, -1, 0, 0, 1, 2);

        // Nested 2x3 loops.
        t_n = 6;
        for (int o = 0; o < 2; o++) begin
            for (int i = 0; i < 3; i++) begin
                t_offs[o*3+i][0] = 32'(o * 'h100 + i * 4 + 4);
                for (int k = 1; k < NS; k++) t_offs[o*3+i][k] = 32'(o * 'h1000 + i * 'h10 * k);
                t_idx[o*3+i]  = {8'(o), 8'(i)};
                t_loop[o*3+i] = (i == 0) && (o > 0);
                t_done[o*3+i] = (o == 1) && (i == 2);
            end
        end
        run_seq({32'h0, 32'h10_0000, 32'h20_0000, 32'h8000}, -1, 0, 0, 0, 6);

        // Iteration counter saturation.
        single_loop(9, 4);
        run_seq({32'h0, 32'h0, 32'h0, 32'h100}, -1, 0, 0, 0, 7);

        // Asynchronous reset mid-sequence.
        single_loop(4, 8);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) chk($sformatf("async_rst_ctrl%0d", g), ctrl[g], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
